// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the multiplier display path: the converter
// FSM state encoding and the width of one BCD digit.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_W = 4;

endpackage : seq_mult_pkg

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: a digit of 5 or more gets 3
// added so the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import seq_mult_pkg::*;
(
  input  logic [BCD_W-1:0] d_in,
  output logic [BCD_W-1:0] d_out
);

  assign d_out = (d_in >= BCD_W'(5)) ? d_in + BCD_W'(3) : d_in;

endmodule : bcd_digit_adj

// File: rtl/seq_bin2bcd.sv
// Sequential shift-and-add-3 binary to BCD converter, one bit per cycle.
// Optional leading-zero blank flags are built when BIN2BCD_BLANK_EN is defined.
module seq_bin2bcd
  import seq_mult_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]       blank
);

  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int BCD_TW = BCD_W * DIGITS;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIN_W-1:0]    r_shreg;
  logic [BCD_TW-1:0]   r_digits;
  logic [BCD_TW-1:0]   r_bcd;
  logic                r_busy;
  logic                r_done;

  logic [BCD_TW-1:0]   w_adj;
  logic [BCD_TW-1:0]   w_digits_next;
  logic [BIN_W-1:0]    w_shreg_next;
  logic                w_last;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .d_in  (r_digits[gi*BCD_W +: BCD_W]),
        .d_out (w_adj[gi*BCD_W +: BCD_W])
      );
    end
  endgenerate

  // Correct then shift in the same cycle; the adjusted MSB falls off the top.
  assign {w_digits_next, w_shreg_next} = {w_adj, r_shreg} << 1;
  assign w_last = (r_cnt == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shreg  <= '0;
      r_digits <= '0;
      r_bcd    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_shreg  <= bin;
            r_digits <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_digits <= w_digits_next;
          r_shreg  <= w_shreg_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_bcd   <= w_digits_next;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;

  // The ones digit is never blanked so a zero result still shows "0".
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_ones
        assign w_blank[gi] = 1'b0;
      end else begin : g_upper
        assign w_blank[gi] = (w_digits_next[BCD_TW-1:gi*BCD_W] == '0);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      r_blank <= '0;
    end else if (r_state == SHIFT && w_last) begin
      r_blank <= w_blank;
    end
  end

  assign blank = r_blank;
`else
  assign blank = '0;
`endif

endmodule : seq_bin2bcd
